// File: rtl/div_32.sv
// div_32: multi-cycle 32-bit radix-2 restoring divider, signed or unsigned.
// It produces one quotient bit per clock and uses a start/busy/done handshake.
// Divide-by-zero and signed overflow are resolved early and skip the iteration loop.
module div_32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        signed_flag,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   typedef enum logic [1:0] {StIdle, StPrep, StCalc, StSign} state_e;

   state_e      state_q, state_d;

   // Operands as latched at acceptance
   logic [31:0] x_q, x_d;
   logic [31:0] y_q, y_d;
   logic        sgn_q, sgn_d;

   // Iteration datapath: quotient bits shift into dvd_q as the dividend shifts out
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [32:0] prem_q, prem_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        special_q, special_d;

   // Result registers
   logic [31:0] quotient_q, quotient_d;
   logic [31:0] remainder_q, remainder_d;
   logic        done_q, done_d;

   logic [31:0] abs_x, abs_y;
   logic        div_zero, sgn_ovf;
   logic [32:0] shifted, trial;

   assign abs_x    = (sgn_q && x_q[31]) ? (32'd0 - x_q) : x_q;
   assign abs_y    = (sgn_q && y_q[31]) ? (32'd0 - y_q) : y_q;
   assign div_zero = (y_q == 32'd0);
   assign sgn_ovf  = sgn_q && (x_q == 32'h8000_0000) && (y_q == 32'hFFFF_FFFF);

   // Shifted partial remainder stays below 2*divisor, so bit 32 of trial is a valid sign
   assign shifted  = {prem_q[31:0], dvd_q[31]};
   assign trial    = shifted - {1'b0, dvs_q};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StPrep;
         StPrep: state_d = (div_zero || sgn_ovf) ? StSign : StCalc;
         StCalc: if (cnt_q == 5'd31) state_d = StSign;
         StSign: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q != StIdle);
      done = done_q;
   end

   // Datapath next-state: operand latch, preparation, iteration and sign fix-up
   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      sgn_d       = sgn_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      prem_d      = prem_q;
      cnt_d       = cnt_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      special_d   = special_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               x_d   = x;
               y_d   = y;
               sgn_d = signed_flag;
            end
         end
         StPrep: begin
            qneg_d    = x_q[31] ^ y_q[31];
            rneg_d    = x_q[31];
            cnt_d     = 5'd0;
            dvs_d     = abs_y;
            special_d = div_zero || sgn_ovf;
            if (div_zero) begin
               dvd_d  = 32'hFFFF_FFFF;
               prem_d = {1'b0, x_q};
            end else if (sgn_ovf) begin
               dvd_d  = 32'h8000_0000;
               prem_d = 33'd0;
            end else begin
               dvd_d  = abs_x;
               prem_d = 33'd0;
            end
         end
         StCalc: begin
            if (!trial[32]) begin
               prem_d = trial;
               dvd_d  = {dvd_q[30:0], 1'b1};
            end else begin
               prem_d = shifted;
               dvd_d  = {dvd_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
         end
         StSign: begin
            quotient_d  = (sgn_q && qneg_q && !special_q) ? (32'd0 - dvd_q) : dvd_q;
            remainder_d = (sgn_q && rneg_q && !special_q) ? (32'd0 - prem_q[31:0])
                                                          : prem_q[31:0];
            done_d      = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q         <= 32'd0;
         y_q         <= 32'd0;
         sgn_q       <= 1'b0;
         dvd_q       <= 32'd0;
         dvs_q       <= 32'd0;
         prem_q      <= 33'd0;
         cnt_q       <= 5'd0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         special_q   <= 1'b0;
         quotient_q  <= 32'd0;
         remainder_q <= 32'd0;
         done_q      <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         sgn_q       <= sgn_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         prem_q      <= prem_d;
         cnt_q       <= cnt_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         special_q   <= special_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         done_q      <= done_d;
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule
